// File: rtl/aging_monitor_array.sv
// Multi-channel aging-sensor controller.
// Opens a detection window for the monitor cells and synchronises their raw warning
// flags. It counts warning cycles per channel inside each window and latches sticky
// alarms when a count reaches the programmed threshold.
module aging_monitor_array #(
    parameter int NUM_CH      = 8,
    parameter int CNT_W       = 8,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [WIN_W-1:0]        win_len,
    input  logic [CNT_W-1:0]        threshold,
    input  logic                    clr_alarm,
    input  logic [NUM_CH-1:0]       warn_raw,
    output logic                    detect_window,
    output logic                    busy,
    output logic                    meas_done,
    output logic [NUM_CH-1:0]       alarm,
    output logic                    alarm_any,
    output logic [NUM_CH*CNT_W-1:0] cnt_flat
);

    localparam int DRN_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DRAIN   = 2'd2,
        EVAL    = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                start_win;
    logic [WIN_W-1:0]    win_left;
    logic [DRN_W-1:0]    drain_left;

    logic [NUM_CH-1:0]   warn_sync_p [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] win_p;
    logic [NUM_CH-1:0]   warn_s;
    logic                win_q;

    logic [CNT_W-1:0]    cnt [NUM_CH];
    logic [NUM_CH-1:0]   hit;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. start_win marks every entry into MEASURE, from IDLE or from EVAL.
    always_comb begin
        next_state = state;
        start_win  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    next_state = MEASURE;
                    start_win  = 1'b1;
                end
            end
            MEASURE: begin
                if (win_left == '0) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_left == '0) begin
                    next_state = EVAL;
                end
            end
            EVAL: begin
                if (en) begin
                    next_state = MEASURE;
                    start_win  = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are pure decodes of the state, so reset forces them low immediately.
    always_comb begin
        detect_window = (state == MEASURE);
        busy          = (state != IDLE);
        meas_done     = (state == EVAL);
        alarm_any     = |alarm;
    end

    // Window and drain timers.
    // win_len is captured only on entry, and a zero length is treated as one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_left   <= '0;
            drain_left <= '0;
        end else begin
            if (start_win) begin
                win_left <= (win_len == '0) ? '0 : win_len - 1'b1;
            end else if (state == MEASURE && win_left != '0) begin
                win_left <= win_left - 1'b1;
            end
            if (state == MEASURE && next_state == DRAIN) begin
                drain_left <= DRN_W'(SYNC_STAGES - 1);
            end else if (state == DRAIN && drain_left != '0) begin
                drain_left <= drain_left - 1'b1;
            end
        end
    end

    // Synchronise warn_raw, and delay detect_window by the same depth so the two stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                warn_sync_p[s] <= '0;
            end
            win_p <= '0;
        end else begin
            warn_sync_p[0] <= warn_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                warn_sync_p[s] <= warn_sync_p[s-1];
            end
            win_p <= {win_p[SYNC_STAGES-2:0], detect_window};
        end
    end

    assign warn_s = warn_sync_p[SYNC_STAGES-1];
    assign win_q  = win_p[SYNC_STAGES-1];

    // Per-channel warning counters.
    // They clear on every window start, otherwise count synchronised warnings while win_q is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (start_win) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (win_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (warn_s[i]) begin
                    cnt[i] <= sat_inc(cnt[i]);
                end
            end
        end
    end

    // Threshold compare and flattening of the counters onto cnt_flat.
    always_comb begin
        hit      = '0;
        cnt_flat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i]                     = (cnt[i] >= threshold);
            cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    // Sticky alarms.
    // If clr_alarm arrives in EVAL, bits set by this evaluation survive and all others clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm <= '0;
        end else if (state == EVAL) begin
            alarm <= clr_alarm ? hit : (alarm | hit);
        end else if (clr_alarm) begin
            alarm <= '0;
        end
    end

endmodule

// File: tb/tb_aging_monitor_array.sv
// Directed testbench for aging_monitor_array with hand-computed expectations.
module tb_aging_monitor_array;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] win_len;
    logic [7:0]  threshold;
    logic        clr_alarm;
    logic [7:0]  warn_raw;
    logic        detect_window;
    logic        busy;
    logic        meas_done;
    logic [7:0]  alarm;
    logic        alarm_any;
    logic [63:0] cnt_flat;

    int n_checks = 0;
    int n_pass   = 0;

    aging_monitor_array #(
        .NUM_CH(8), .CNT_W(8), .WIN_W(16), .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .win_len(win_len),
        .threshold(threshold),
        .clr_alarm(clr_alarm),
        .warn_raw(warn_raw),
        .detect_window(detect_window),
        .busy(busy),
        .meas_done(meas_done),
        .alarm(alarm),
        .alarm_any(alarm_any),
        .cnt_flat(cnt_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle. Starts one window and drives warnings
    // with mask during the first nwarn window cycles. Returns at the negedge where
    // meas_done is seen. lat counts cycles from the detect_window rise to meas_done
    // inclusive; dwc counts the cycles with detect_window high.
    task automatic do_window(input logic [15:0] wl, input logic [7:0] mask, input int nwarn,
                             input logic stay_en, output int lat, output int dwc);
        int guard;
        lat = 0;
        dwc = 0;
        win_len = wl;
        en = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!detect_window && guard < 10);
        if (!detect_window) begin
            check("dw_rise", 64'(detect_window), 64'd1);
            return;
        end
        lat = 1;
        dwc = 1;
        warn_raw = (nwarn >= 1) ? mask : 8'h00;
        win_len = 16'd1;
        if (!stay_en) en = 1'b0;
        guard = 0;
        while (!meas_done && guard < 2000) begin
            @(negedge clk);
            lat++;
            guard++;
            if (detect_window) dwc++;
            warn_raw = (lat <= nwarn) ? mask : 8'h00;
        end
        if (!meas_done) check("meas_done_timeout", 64'(meas_done), 64'd1);
        warn_raw = 8'h00;
    endtask

    initial begin
        int lat;
        int dwc;
        int pulses;
        int guard;

        rst_n     = 1'b0;
        en        = 1'b0;
        win_len   = 16'd0;
        threshold = 8'd0;
        clr_alarm = 1'b0;
        warn_raw  = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_detect", 64'(detect_window), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(meas_done), 64'd0);
        check("rst_alarm", 64'(alarm), 64'd0);
        check("rst_cnt", cnt_flat, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic window: ch2 warns for 5 of 10 window cycles, threshold 3.
        threshold = 8'd3;
        do_window(16'd10, 8'h04, 5, 1'b0, lat, dwc);
        check("t1_latency", 64'(lat), 64'd13);
        check("t1_dw_cycles", 64'(dwc), 64'd10);
        check("t1_cnt", cnt_flat, 64'h0000000000050000);
        @(negedge clk);
        check("t1_alarm", 64'(alarm), 64'h04);
        check("t1_alarm_any", 64'(alarm_any), 64'd1);
        check("t1_busy_idle", 64'(busy), 64'd0);
        check("t1_cnt_hold", cnt_flat, 64'h0000000000050000);

        // Saturation: ch0 held high over a 300-cycle window.
        threshold = 8'd255;
        do_window(16'd300, 8'h01, 300, 1'b0, lat, dwc);
        check("t2_latency", 64'(lat), 64'd303);
        check("t2_cnt_sat", cnt_flat, 64'h00000000000000FF);
        @(negedge clk);
        check("t2_alarm", 64'(alarm), 64'h05);

        // clr_alarm while idle.
        clr_alarm = 1'b1;
        @(negedge clk);
        clr_alarm = 1'b0;
        check("clr_idle", 64'(alarm), 64'h00);
        check("clr_idle_any", 64'(alarm_any), 64'd0);

        // Threshold zero alarms on every channel.
        threshold = 8'd0;
        do_window(16'd4, 8'h00, 0, 1'b0, lat, dwc);
        check("t3_latency", 64'(lat), 64'd7);
        @(negedge clk);
        check("t3_alarm_all", 64'(alarm), 64'hFF);
        clr_alarm = 1'b1;
        @(negedge clk);
        clr_alarm = 1'b0;
        check("t3_clr", 64'(alarm), 64'h00);

        // clr_alarm on the EVAL cycle: the ch1 set wins, the older ch3 alarm clears.
        threshold = 8'd2;
        do_window(16'd3, 8'h08, 3, 1'b0, lat, dwc);
        @(negedge clk);
        check("t4_pre_alarm", 64'(alarm), 64'h08);
        do_window(16'd5, 8'h02, 2, 1'b0, lat, dwc);
        clr_alarm = 1'b1;
        @(negedge clk);
        clr_alarm = 1'b0;
        check("t4_set_wins", 64'(alarm), 64'h02);

        // en dropped mid-window: the window completes with exactly one meas_done.
        do_window(16'd6, 8'h00, 0, 1'b0, lat, dwc);
        check("t5_latency", 64'(lat), 64'd9);
        check("t5_dw_cycles", 64'(dwc), 64'd6);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (meas_done) pulses++;
        end
        check("t5_no_extra_done", 64'(pulses), 64'd0);
        check("t5_busy_idle", 64'(busy), 64'd0);

        // win_len=0 gives a single-cycle window.
        do_window(16'd0, 8'h00, 0, 1'b0, lat, dwc);
        check("t5_wl0_dw", 64'(dwc), 64'd1);
        check("t5_wl0_latency", 64'(lat), 64'd4);
        @(negedge clk);

        // Back-to-back windows with en held high.
        do_window(16'd5, 8'h10, 5, 1'b1, lat, dwc);
        check("b2b_cnt", cnt_flat, 64'h0000000500000000);
        @(negedge clk);
        check("b2b_restart_dw", 64'(detect_window), 64'd1);
        check("b2b_cnt_clear", cnt_flat, 64'd0);
        en = 1'b0;
        guard = 0;
        while (!meas_done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("b2b_second_done", 64'(meas_done), 64'd1);
        @(negedge clk);
        check("b2b_idle", 64'(busy), 64'd0);
        check("b2b_alarm", 64'(alarm), 64'h12);

        // Asynchronous reset in the middle of a window.
        win_len  = 16'd50;
        en       = 1'b1;
        warn_raw = 8'hFF;
        guard = 0;
        while (!detect_window && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) @(negedge clk);
        check("t6_counting", 64'(cnt_flat != 64'd0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_dw", 64'(detect_window), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_alarm", 64'(alarm), 64'h00);
        check("t6_rst_cnt", cnt_flat, 64'd0);
        en       = 1'b0;
        warn_raw = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_window(16'd4, 8'h20, 2, 1'b0, lat, dwc);
        check("t6_fresh_latency", 64'(lat), 64'd7);
        check("t6_fresh_cnt", cnt_flat, 64'h0000020000000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
